// File: rtl/pdm_decimator_pkg.sv
// Shared constants and types for the PDM receive path.
// CIC decimator sizing, accumulator type and comb FSM states.
package pdm_decimator_pkg;

  localparam int SYNTH_WIDTH  = 16;
  localparam int PDM_DECIM    = 256;
  localparam int CIC_STAGES   = 4;
  localparam int CIC_ACC_BITS = 34;

  typedef logic signed [CIC_ACC_BITS-1:0] cic_acc_t;

  typedef enum logic [1:0] {
    IDLE,
    COMB,
    EMIT
  } cic_state_t;

endpackage

// File: rtl/pdm_decimator_cic_integrator.sv
// Single enable-gated wrapping integrator stage.
// Overflow wraps modulo 2^W; the comb stages undo it exactly.
module cic_integrator #(
  parameter int W = 34
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  input  logic [W-1:0] addend,
  output logic [W-1:0] acc
);

  // accumulate on each qualified input strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + addend;
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// PDM to PCM CIC decimator: integrators at bit rate,
// a shared-subtractor comb sequencer at sample rate.
module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int WIDTH  = SYNTH_WIDTH,
  parameter int DECIM  = PDM_DECIM,
  parameter int STAGES = CIC_STAGES
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    data_in,
  input  logic                    data_valid_in,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    sample_valid_out
);

  localparam int LOG_R = $clog2(DECIM);
  localparam int ACC_W = STAGES * LOG_R + 2;
  localparam int SHIFT = STAGES * LOG_R - (WIDTH - 1);
  localparam int KW    = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((longint'(1) <<< (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] integ [STAGES];
  logic [LOG_R-1:0] dcnt;
  logic             tick;

  logic signed [ACC_W-1:0] snapshot;
  logic signed [ACC_W-1:0] work;
  logic signed [ACC_W-1:0] dly [STAGES];
  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] comb_y;
  logic signed [ACC_W-1:0] shifted;
  logic signed [WIDTH-1:0] sat_val;

  cic_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;

  assign x    = data_in ? ACC_W'(1) : '1;
  assign tick = data_valid_in && (dcnt == LOG_R'(DECIM - 1));

  for (genvar g = 0; g < STAGES; g++) begin : g_integ
    logic [ACC_W-1:0] addend;
    if (g == 0) begin : g_first
      assign addend = x;
    end else begin : g_rest
      assign addend = integ[g-1];
    end
    cic_integrator #(
      .W(ACC_W)
    ) u_integ (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .en    (data_valid_in),
      .addend(addend),
      .acc   (integ[g])
    );
  end

  // decimation counter wraps naturally at the power-of-two ratio
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dcnt <= '0;
    end else if (data_valid_in) begin
      dcnt <= dcnt + LOG_R'(1);
    end
  end

  // comb state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // comb next-state: one stage per cycle, then emit
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = COMB;
          k_d     = '0;
        end
      end
      COMB: begin
        if (k_q == KW'(STAGES - 1)) begin
          state_d = EMIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // shared comb subtractor; first stage reads the snapshot
  always_comb begin
    operand = (k_q == '0) ? snapshot : work;
    comb_y  = operand - dly[k_q];
  end

  // scale to output width and clamp
  always_comb begin
    shifted = work >>> SHIFT;
    if (shifted > SAT_HI) begin
      sat_val = WIDTH'(SAT_HI);
    end else if (shifted < SAT_LO) begin
      sat_val = WIDTH'(SAT_LO);
    end else begin
      sat_val = WIDTH'(shifted);
    end
  end

  // snapshot, comb delays, work register and output strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      snapshot         <= '0;
      work             <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        dly[i] <= '0;
      end
    end else begin
      sample_valid_out <= 1'b0;
      if (tick) begin
        snapshot <= integ[STAGES-1];
      end
      if (state_q == COMB) begin
        dly[k_q] <= operand;
        work     <= comb_y;
      end
      if (state_q == EMIT) begin
        sample_out       <= sat_val;
        sample_valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator.
// Reference: direct CIC kernel convolution over the bit history.
module tb_pdm_decimator;

  localparam int R    = 256;
  localparam int N    = 4;
  localparam int S    = 17;
  localparam int HLEN = N * (R - 1) + 1;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               data_in;
  logic               data_valid_in;
  logic signed [15:0] sample_out;
  logic               sample_valid_out;

  pdm_decimator dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int due;
    int val;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    int         plen;
    int         sper;
    int         nsamp;
    int         expv;
    int         tol;
  } vec_t;

  longint h [HLEN];
  int     hist [$];
  exp_t   exq [$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     nstrobe = 0;
  int     nsamp = 0;
  int     hold = 0;
  bit     steady_on = 0;
  int     steady_exp = 0;
  int     steady_tol = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 name, act, expv, cyc);
    end
  endtask

  function automatic void build_kernel();
    longint tmp [HLEN];
    int len = 1;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    for (int st = 0; st < N; st++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int t = 0; t < R; t++)
          if (i - t >= 0 && i - t < len) tmp[i] += h[i-t];
      end
      len += R - 1;
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end
  endfunction

  // tick at strobe j sees integrator output through input j-N
  function automatic int model_sample(input int j);
    longint y = 0;
    longint v;
    for (int i = 0; i < HLEN; i++) begin
      int idx = j - N - i;
      if (idx >= 0) y += h[i] * longint'(hist[idx]);
    end
    v = y >>> S;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  task automatic step(input logic v, input logic b, input logic r);
    rst_in        = r;
    data_valid_in = v;
    data_in       = b;
    if (r) begin
      hist.delete();
      exq.delete();
      nstrobe = 0;
      nsamp   = 0;
      hold    = 0;
    end else if (v) begin
      hist.push_back(b ? 1 : -1);
      if (nstrobe % R == R - 1) begin
        exp_t e;
        e.due = cyc + N + 2;
        e.val = model_sample(nstrobe);
        exq.push_back(e);
      end
      nstrobe++;
    end
    @(posedge clk_in);
    cyc++;
    #1;
    if (exq.size() > 0 && exq[0].due == cyc) begin
      chk("valid_pulse", int'(sample_valid_out), 1);
      chk("sample_model", int'(sample_out), exq[0].val);
      hold = exq[0].val;
      if (steady_on && nsamp >= N) begin
        int d = int'(sample_out) - steady_exp;
        n_cmp++;
        if (d > steady_tol || d < -steady_tol) begin
          n_bad++;
          if (n_bad <= 30)
            $display("FAIL steady: got %0d expected %0d +/-%0d",
                     int'(sample_out), steady_exp, steady_tol);
        end
      end
      nsamp++;
      void'(exq.pop_front());
    end else begin
      chk("valid_idle", int'(sample_valid_out), 0);
    end
    chk("hold", int'(sample_out), hold);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  vec_t vt [6];

  initial begin
    rst_in        = 1'b1;
    data_in       = 1'b0;
    data_valid_in = 1'b0;
    build_kernel();

    vt[0] = '{8'b0000_0001, 1, 1, 8, 32767, 0};
    vt[1] = '{8'b0000_0000, 1, 1, 8, -32768, 0};
    vt[2] = '{8'b0000_0001, 2, 1, 8, 0, 1};
    vt[3] = '{8'b0000_0111, 4, 1, 8, 16384, 0};
    vt[4] = '{8'b0000_0001, 4, 1, 8, -16384, 0};
    vt[5] = '{8'b0000_0111, 4, 8, 6, 16384, 0};

    do_reset();
    chk("reset_sample", int'(sample_out), 0);
    chk("reset_valid", int'(sample_valid_out), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      steady_on  = 1;
      steady_exp = vt[v].expv;
      steady_tol = vt[v].tol;
      for (int s = 0; s < vt[v].nsamp * R; s++) begin
        step(1'b1, vt[v].pat[s % vt[v].plen], 1'b0);
        idle(vt[v].sper - 1);
      end
      idle(N + 4);
      chk("samples_seen", nsamp, vt[v].nsamp);
    end
    steady_on = 0;

    // reset two cycles after a tick: pulse must be suppressed
    do_reset();
    for (int s = 0; s < 2 * R; s++) step(1'b1, 1'(s % 4 != 3), 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("midcomb_rst_sample", int'(sample_out), 0);
    for (int s = 0; s < R + 8; s++) step(1'b1, 1'(s % 4 != 3), 1'b0);
    chk("midcomb_next_count", nsamp, 1);

    // reset on the emit edge
    do_reset();
    for (int s = 0; s < 2 * R; s++) step(1'b1, 1'b1, 1'b0);
    idle(N);
    step(1'b0, 1'b0, 1'b1);
    chk("midemit_valid", int'(sample_valid_out), 0);
    chk("midemit_sample", int'(sample_out), 0);
    idle(4);

    // random bits with random strobe spacing
    do_reset();
    for (int s = 0; s < 6 * R; s++) begin
      step(1'b1, 1'($urandom), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(N + 4);
    chk("drained", exq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Decodes a 1-bit pulse-density-modulated stream, such as a PDM microphone or a loopback of the speaker modulator, into signed PCM samples. It is the receive-side counterpart of the delta-sigma `pdm` modulator. A CIC decimator (integrators at the bit rate, combs at the sample rate) reduces the 12.3 MHz bit stream by 256x to 48 kHz PCM. The block sits in the 98.3 MHz audio clock domain and feeds the vocoder analysis path.

## Interface
Parameters:
- `WIDTH`, 16: output sample width, signed two's complement.
- `DECIM`, 256: decimation ratio R. Must be a power of two and ≥ `STAGES`+2.
- `STAGES`, 4: CIC order N.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  input  1  98.3 MHz audio clock.
- `rst_in`  input  1  synchronous active-high reset.
- `data_in`  input  1  PDM bit. 1 means +1, 0 means −1.
- `data_valid_in`  input  1  one-cycle strobe that qualifies `data_in`.
- `sample_out`  output  `WIDTH`  signed decimated sample. Held between strobes.
- `sample_valid_out`  output  1  one-cycle pulse when `sample_out` updates.

## Operation
- Accumulator width `ACC_W` = `STAGES`·log2(`DECIM`)+2, which is 34 at the defaults. All integrator and comb arithmetic is modulo 2^`ACC_W`; wrap-around is intentional and must not be saturated.
- Input map: x = +1 when `data_in`=1, −1 otherwise, sign-extended to `ACC_W`.
- Integrators, updated only on `data_valid_in`:
  - integ[0] ← integ[0]+x
  - integ[k] ← integ[k]+integ[k−1], using pre-update values (pipelined cascade)
- Decimation counter `dcnt` counts valid strobes from 0 to `DECIM`−1 and then wraps.
- On the valid strobe with `dcnt`=`DECIM`−1 (the decimation tick):
  - snapshot ← the pre-update value of integ[`STAGES`−1]
  - the comb FSM starts
- Comb FSM states:
  - IDLE: wait for the decimation tick, then go to COMB with k=0.
  - COMB: one stage per cycle. y = work − dly[k]; dly[k] ← work; work ← y. After k=`STAGES`−1, go to EMIT.
  - EMIT: `sample_out` ← sat(work >>> S), where S = `STAGES`·log2(`DECIM`) − (`WIDTH`−1), which is 17 at the defaults. Assert `sample_valid_out`, then go to IDLE.
- sat() clamps to [−2^(`WIDTH`−1), 2^(`WIDTH`−1)−1]. Full-scale +1 input therefore saturates to 32767 and full-scale −1 input gives −32768.
- Integrators keep running while the FSM is busy. The comb path works only on the latched snapshot.
- The first `STAGES` output samples after reset are start-up transient. Consumers discard them.

## Timing
- Reset values: integrators, comb delays, snapshot, work, `dcnt`, `sample_out` = 0; `sample_valid_out` = 0; FSM = IDLE.
- Latency: a decimation tick sampled at edge t produces `sample_valid_out` high for exactly the cycle after edge t+`STAGES`+1. At the defaults that is 5 cycles after the tick.
- `data_valid_in` may be asserted every cycle or sparsely; the design uses every 8th cycle. Back-to-back ticks are at least `DECIM` cycles apart, so the FSM is always back in IDLE before the next tick. No overrun handling is required.
- `data_in` is ignored while `data_valid_in`=0.
- `rst_in` asserted mid-COMB or mid-EMIT aborts the FSM. No `sample_valid_out` pulse may follow, and all state returns to reset values on the next edge.
- `rst_in` takes priority over a simultaneous `data_valid_in`.

## Structure
- `constants` package additions:
  - `PDM_DECIM` = 256
  - `CIC_STAGES` = 4
  - `CIC_ACC_BITS` = 34
  - `typedef logic signed [CIC_ACC_BITS-1:0] cic_acc_t`
  - comb FSM state enum `cic_state_t` (IDLE, COMB, EMIT)
- Output width reuses `SYNTH_WIDTH`.
- One sub-module, `cic_integrator`, which is a single enable-gated wrapping integrator. It is instantiated `STAGES` times in a generate loop. The comb stages stay inline and share one subtractor.

## Test plan
- All-ones input with a strobe every cycle, past the transient -> every `sample_out` = 32767, pulses every 256 cycles.
- All-zeros input -> `sample_out` = −32768 steady.
- Alternating 1010… -> `sample_out` = 0 steady (within ±1 LSB).
- Repeating 1110 -> +16384; repeating 1000 -> −16384.
- Strobe every 8 cycles with the 1110 pattern -> same +16384; `sample_valid_out` period is 2048 cycles and each pulse is exactly one cycle wide, 5 cycles after the tick.
- Assert `rst_in` for one cycle two cycles after a tick -> no pulse for that tick, `sample_out` = 0, `dcnt` restarts, and the next pulse arrives 256 strobes later.
